// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - frame handshake between a frame source and the UART serializer
interface uart_tx_serializer_if #(
  parameter int FRAME_BITS = 11
);
  logic [FRAME_BITS-1:0] frame_in;
  logic                  frame_valid;
  logic                  frame_ready;

  modport master (
    output frame_in,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_in,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - shifts a pre-assembled frame out MSB first, CLKS_PER_BIT cycles per bit
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FRAME_BITS   = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_tx_serializer_if.slave    frame_if,
  output logic                   tx,
  output logic                   busy,
  output logic                   tx_done
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(FRAME_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01
  } state_t;

  state_t                state;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [FRAME_BITS-1:0] shift_reg;
  logic                  frame_ready_q;

  assign frame_if.frame_ready = frame_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tx            <= 1'b1;
      busy          <= 1'b0;
      tx_done       <= 1'b0;
      frame_ready_q <= 1'b1;
      baud_cnt      <= '0;
      bit_idx       <= '0;
      shift_reg     <= '1;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_if.frame_valid && frame_ready_q) begin
            state         <= SHIFT;
            shift_reg     <= frame_if.frame_in;
            tx            <= frame_if.frame_in[FRAME_BITS-1];
            busy          <= 1'b1;
            frame_ready_q <= 1'b0;
            baud_cnt      <= '0;
            bit_idx       <= '0;
          end
        end
        SHIFT: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            // The final wrap releases the line high and frees the block in the same edge.
            if (bit_idx == IDX_LAST) begin
              state         <= IDLE;
              tx            <= 1'b1;
              busy          <= 1'b0;
              tx_done       <= 1'b1;
              frame_ready_q <= 1'b1;
              bit_idx       <= '0;
              shift_reg     <= '1;
            end else begin
              shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b1};
              tx        <= shift_reg[FRAME_BITS-2];
              bit_idx   <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          tx            <= 1'b1;
          busy          <= 1'b0;
          frame_ready_q <= 1'b1;
          baud_cnt      <= '0;
          bit_idx       <= '0;
          shift_reg     <= '1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;
  localparam int CPB   = 4;
  localparam int FB    = 11;
  localparam int NB    = CPB * FB;
  localparam int CPB_D = 434;
  localparam int NB_D  = CPB_D * FB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic tx, busy, tx_done;
  logic tx_d, busy_d, done_d;

  uart_tx_serializer_if #(.FRAME_BITS(FB)) fa ();
  uart_tx_serializer_if #(.FRAME_BITS(FB)) fd ();

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .FRAME_BITS(FB)) dut (
    .clk(clk), .rst(rst), .frame_if(fa.slave), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(CPB_D), .FRAME_BITS(FB)) dut_d (
    .clk(clk), .rst(rst), .frame_if(fd.slave), .tx(tx_d), .busy(busy_d), .tx_done(done_d)
  );

  int checks = 0;
  int errors = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural model: a frame occupies NB cycles after acceptance, then one done cycle.
  bit          m_on = 1'b0;
  bit          m_active = 1'b0;
  bit          m_shifting;
  int          m_cnt = 0;
  logic [FB-1:0] m_frame = '1;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_cnt    = 0;
    end else begin
      m_shifting = m_active && (m_cnt <= NB);
      if (!m_shifting && fa.frame_valid) begin
        m_active = 1'b1;
        m_cnt    = 1;
        m_frame  = fa.frame_in;
      end else if (m_active) begin
        m_cnt++;
        if (m_cnt > NB + 1) begin
          m_active = 1'b0;
          m_cnt    = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      logic e_busy, e_tx, e_done;
      e_busy = m_active && (m_cnt <= NB);
      e_done = m_active && (m_cnt == NB + 1);
      e_tx   = e_busy ? m_frame[FB - 1 - (m_cnt - 1) / CPB] : 1'b1;
      check1("model_tx", tx, e_tx);
      check1("model_busy", busy, e_busy);
      check1("model_ready", fa.frame_ready, !e_busy);
      check1("model_done", tx_done, e_done);
    end
  end

  logic s_tx [0:127];
  logic s_busy [0:127];
  logic s_done [0:127];
  logic s_ready [0:127];

  // kind: 0 plain, 1 valid pulse of 11'h000 at inj_k, 2 rst pulse at inj_k, 3 back-to-back with 11'h7FE
  task automatic run_frame(input logic [FB-1:0] f, input int ncyc, input int inj_k, input int kind);
    @(posedge clk); #1;
    fa.frame_valid = 1'b1;
    fa.frame_in    = f;
    @(posedge clk); #1;
    if (kind == 3) fa.frame_in = 11'h7FE;
    else fa.frame_valid = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      s_tx[k]    = tx;
      s_busy[k]  = busy;
      s_done[k]  = tx_done;
      s_ready[k] = fa.frame_ready;
      if (kind == 1 && k == inj_k) begin
        fa.frame_valid = 1'b1;
        fa.frame_in    = '0;
      end
      if (kind == 1 && k == inj_k + 1) fa.frame_valid = 1'b0;
      if (kind == 2 && k == inj_k) rst = 1'b1;
      if (kind == 2 && k == inj_k + 1) rst = 1'b0;
      if (kind == 3 && k == NB + 2) fa.frame_valid = 1'b0;
    end
  endtask

  task automatic check_a5_wave(input string tag);
    logic [FB-1:0] exp_bits;
    exp_bits = 11'b01010010101;
    for (int i = 0; i < FB; i++) begin
      check1($sformatf("%s_bit%0d", tag, i), s_tx[CPB * i + 2], exp_bits[FB - 1 - i]);
    end
  endtask

  initial begin
    int busy_cnt, done_cnt, done_at, bad, bsy_d, done_d_at;
    logic [FB-1:0] alt;
    rst = 1'b1;
    fa.frame_valid = 1'b0;
    fa.frame_in    = '0;
    fd.frame_valid = 1'b0;
    fd.frame_in    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("reset_tx", tx, 1'b1);
    check1("reset_busy", busy, 1'b0);
    check1("reset_ready", fa.frame_ready, 1'b1);
    check1("reset_done", tx_done, 1'b0);
    m_on = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single frame 0xA5 with even parity
    run_frame(11'h295, 50, 0, 0);
    check_a5_wave("single");
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int k = 1; k <= 50; k++) begin
      if (s_busy[k]) busy_cnt++;
      if (s_done[k]) begin done_cnt++; if (done_at == 0) done_at = k; end
    end
    checkn("single_busy_cycles", busy_cnt, 44);
    checkn("single_done_cycle", done_at, 45);
    checkn("single_done_count", done_cnt, 1);

    // Valid pulse while busy is ignored
    run_frame(11'h295, 50, 10, 1);
    check1("ignore_ready_at_10", s_ready[10], 1'b0);
    check_a5_wave("ignore");

    // Back-to-back frames
    run_frame(11'h295, 100, 0, 3);
    check1("b2b_done_45", s_done[45], 1'b1);
    check1("b2b_idle_45", s_busy[45], 1'b0);
    check1("b2b_busy_46", s_busy[46], 1'b1);
    check1("b2b_stop_41", s_tx[41], 1'b1);
    check1("b2b_second_first_bit", s_tx[46], 1'b1);
    check1("b2b_second_last_bit", s_tx[86], 1'b0);
    check1("b2b_second_done_90", s_done[90], 1'b1);

    // Reset mid-frame
    run_frame(11'h295, 60, 20, 2);
    check1("rst_mid_tx", s_tx[21], 1'b1);
    check1("rst_mid_busy", s_busy[21], 1'b0);
    check1("rst_mid_ready", s_ready[21], 1'b1);
    done_cnt = 0;
    for (int k = 1; k <= 60; k++) if (s_done[k]) done_cnt++;
    checkn("rst_mid_no_done", done_cnt, 0);
    run_frame(11'h295, 50, 0, 0);
    check_a5_wave("after_rst");
    check1("after_rst_done_45", s_done[45], 1'b1);

    // Reset and valid in the same cycle
    @(posedge clk); #1;
    rst = 1'b1;
    fa.frame_valid = 1'b1;
    fa.frame_in = 11'h295;
    @(posedge clk); #1;
    rst = 1'b0;
    fa.frame_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checkn("collision_no_tx", bad, 0);

    // Default baud timing on the second instance, alternating bits
    alt = 11'b01010101010;
    @(posedge clk); #1;
    fd.frame_valid = 1'b1;
    fd.frame_in    = alt;
    @(posedge clk); #1;
    fd.frame_valid = 1'b0;
    bad = 0; bsy_d = 0; done_d_at = 0;
    for (int k = 1; k <= NB_D + 10; k++) begin
      logic e;
      @(negedge clk);
      e = (k <= NB_D) ? alt[FB - 1 - (k - 1) / CPB_D] : 1'b1;
      if (tx_d !== e) bad++;
      if (busy_d) bsy_d++;
      if (done_d && done_d_at == 0) done_d_at = k;
    end
    checkn("default_bit_timing", bad, 0);
    checkn("default_busy_cycles", bsy_d, 4774);
    checkn("default_done_cycle", done_d_at, 4775);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
